// File: rtl/ascii_cmd_pkg.sv
// ascii_cmd_pkg: shared types and constants for the ASCII command decoder.
// Parser states, command kinds, ASCII codes and keyword lookup helpers.
package ascii_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE, KEYWORD, SP1, ADDR, SP2, DATA, ISSUE, FLUSH
    } state_t;

    typedef enum logic {
        CMD_WRITE, CMD_READ
    } cmd_t;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;

    localparam logic [39:0] KW_WRITE = "write";
    localparam logic [31:0] KW_READ  = "read";

    // Letter i of the keyword, 0 being the first letter.
    function automatic logic [7:0] kw_char(input cmd_t c,
                                           input logic [2:0] i);
        logic [39:0] kw;
        logic [7:0]  ch;
        kw = (c == CMD_WRITE) ? KW_WRITE : {KW_READ, 8'h00};
        case (i)
            3'd0:    ch = kw[39:32];
            3'd1:    ch = kw[31:24];
            3'd2:    ch = kw[23:16];
            3'd3:    ch = kw[15:8];
            3'd4:    ch = kw[7:0];
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    // Index of the final keyword letter.
    function automatic logic [2:0] kw_last(input cmd_t c);
        return (c == CMD_WRITE) ? 3'd4 : 3'd3;
    endfunction

endpackage

// File: rtl/ascii_command_decoder_hex.sv
// hex_char_decoder: combinational ASCII hex digit to nibble.
// Ports: ch (ASCII in), nibble (value), is_hex (ch is 0-9/a-f/A-F).
module hex_char_decoder (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        unique case (1'b1)
            (ch >= "0" && ch <= "9"): begin
                nibble = ch[3:0];
                is_hex = 1'b1;
            end
            (ch >= "a" && ch <= "f"),
            (ch >= "A" && ch <= "F"): begin
                // low nibble of 'a'/'A' is 1, so +9 gives 10
                nibble = ch[3:0] + 4'd9;
                is_hex = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ascii_command_decoder.sv
// ascii_command_decoder: parses "write <a> <d>\n" / "read <a>\n" lines
// from a valid/ready byte stream into single cs/we bus requests.
// Ports: clk, reset (async high); tvalid/tdata/tready byte stream;
// addr/wdata/we/cs bus request held until ack; irq pulses on bad syntax.
module ascii_command_decoder
    import ascii_cmd_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tvalid,
    input  logic [7:0]        tdata,
    output logic              tready,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              cs,
    output logic              irq,
    input  logic              ack
);

    localparam int AD = ADDR_W / 4;
    localparam int DD = DATA_W / 4;
    localparam int AC = $clog2(AD + 1);
    localparam int DC = $clog2(DD + 1);

    state_t            state, state_n;
    cmd_t              cmd, cmd_n;
    logic [2:0]        idx, idx_n;
    logic              sep, sep_n;
    logic              tail, tail_n;
    logic [ADDR_W-1:0] acc_a, acc_a_n;
    logic [DATA_W-1:0] acc_d, acc_d_n;
    logic [AC-1:0]     cnt_a, cnt_a_n;
    logic [DC-1:0]     cnt_d, cnt_d_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              we_n, cs_n, irq_n, tready_n;

    logic [3:0] nib;
    logic       is_hex;
    logic       hs, is_sp, is_lf, is_cr;
    logic       err, issue;

    hex_char_decoder u_hex (
        .ch     (tdata),
        .nibble (nib),
        .is_hex (is_hex)
    );

    assign hs    = tvalid && tready;
    assign is_sp = (tdata == SPACE);
    assign is_lf = (tdata == LF);
    assign is_cr = (tdata == CR);

    always_comb begin
        state_n = state;
        cmd_n   = cmd;
        idx_n   = idx;
        sep_n   = sep;
        tail_n  = tail;
        acc_a_n = acc_a;
        acc_d_n = acc_d;
        cnt_a_n = cnt_a;
        cnt_d_n = cnt_d;
        addr_n  = addr;
        wdata_n = wdata;
        we_n    = we;
        cs_n    = cs;
        irq_n   = 1'b0;
        err     = 1'b0;
        issue   = 1'b0;

        if (state == ISSUE) begin
            if (ack) begin
                state_n = IDLE;
                cs_n    = 1'b0;
                we_n    = 1'b0;
            end
        end else if (hs && !is_cr) begin
            unique case (state)
                IDLE: begin
                    if (tdata == "w" || tdata == "r") begin
                        cmd_n   = (tdata == "w") ? CMD_WRITE
                                                 : CMD_READ;
                        idx_n   = 3'd1;
                        state_n = KEYWORD;
                    end else if (!is_sp && !is_lf) begin
                        err = 1'b1;
                    end
                end
                KEYWORD: begin
                    if (tdata != kw_char(cmd, idx)) begin
                        err = 1'b1;
                    end else if (idx == kw_last(cmd)) begin
                        state_n = SP1;
                        sep_n   = 1'b0;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
                // sep records that the mandatory space was seen
                SP1: begin
                    if (is_sp) begin
                        sep_n = 1'b1;
                    end else if (is_hex && sep) begin
                        state_n = ADDR;
                        acc_a_n = ADDR_W'(nib);
                        cnt_a_n = AC'(1);
                        tail_n  = 1'b0;
                    end else begin
                        err = 1'b1;
                    end
                end
                // tail: field closed by a space, only blanks may follow
                ADDR: begin
                    if (is_lf) begin
                        if (cmd == CMD_READ) issue = 1'b1;
                        else                 err   = 1'b1;
                    end else if (tail) begin
                        if (!is_sp) err = 1'b1;
                    end else if (is_sp) begin
                        if (cmd == CMD_WRITE) state_n = SP2;
                        else                  tail_n  = 1'b1;
                    end else if (is_hex && cnt_a != AC'(AD)) begin
                        acc_a_n = (acc_a << 4) | ADDR_W'(nib);
                        cnt_a_n = cnt_a + AC'(1);
                    end else begin
                        err = 1'b1;
                    end
                end
                SP2: begin
                    if (is_hex) begin
                        state_n = DATA;
                        acc_d_n = DATA_W'(nib);
                        cnt_d_n = DC'(1);
                        tail_n  = 1'b0;
                    end else if (!is_sp) begin
                        err = 1'b1;
                    end
                end
                DATA: begin
                    if (is_lf) begin
                        issue = 1'b1;
                    end else if (tail) begin
                        if (!is_sp) err = 1'b1;
                    end else if (is_sp) begin
                        tail_n = 1'b1;
                    end else if (is_hex && cnt_d != DC'(DD)) begin
                        acc_d_n = (acc_d << 4) | DATA_W'(nib);
                        cnt_d_n = cnt_d + DC'(1);
                    end else begin
                        err = 1'b1;
                    end
                end
                FLUSH: begin
                    if (is_lf) state_n = IDLE;
                end
                default: ;
            endcase

            if (issue) begin
                state_n = ISSUE;
                cs_n    = 1'b1;
                we_n    = (cmd == CMD_WRITE);
                addr_n  = acc_a;
                wdata_n = (cmd == CMD_WRITE) ? acc_d : '0;
            end

            if (err) begin
                irq_n   = 1'b1;
                state_n = is_lf ? IDLE : FLUSH;
            end
        end

        tready_n = (state_n != ISSUE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cmd    <= CMD_WRITE;
            idx    <= '0;
            sep    <= 1'b0;
            tail   <= 1'b0;
            acc_a  <= '0;
            acc_d  <= '0;
            cnt_a  <= '0;
            cnt_d  <= '0;
            addr   <= '0;
            wdata  <= '0;
            we     <= 1'b0;
            cs     <= 1'b0;
            irq    <= 1'b0;
            tready <= 1'b0;
        end else begin
            state  <= state_n;
            cmd    <= cmd_n;
            idx    <= idx_n;
            sep    <= sep_n;
            tail   <= tail_n;
            acc_a  <= acc_a_n;
            acc_d  <= acc_d_n;
            cnt_a  <= cnt_a_n;
            cnt_d  <= cnt_d_n;
            addr   <= addr_n;
            wdata  <= wdata_n;
            we     <= we_n;
            cs     <= cs_n;
            irq    <= irq_n;
            tready <= tready_n;
        end
    end

endmodule

// File: tb/tb_ascii_command_decoder.sv
// tb_ascii_command_decoder: directed lines against a line-level model,
// compared every cycle, plus literal expectations on key results.
module tb_ascii_command_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tvalid = 1'b0;
    logic [7:0]  tdata = 8'h00;
    logic        ack = 1'b0;
    logic        tready, we, cs, irq;
    logic [15:0] addr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;

    // expected outputs, owned by the model process
    logic        e_tready = 1'b0, e_we = 1'b0;
    logic        e_cs = 1'b0, e_irq = 1'b0;
    logic [15:0] e_addr = '0;
    logic [31:0] e_wdata = '0;

    // per-byte annotations from the line parser
    bit          cur_err = 1'b0, cur_fin = 1'b0, cur_wr = 1'b0;
    logic [15:0] cur_addr = '0;
    logic [31:0] cur_data = '0;

    always #5 clk = ~clk;

    ascii_command_decoder #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .tvalid (tvalid),
        .tdata  (tdata),
        .tready (tready),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .cs     (cs),
        .irq    (irq),
        .ack    (ack)
    );

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit hx(input logic [7:0] ch);
        return (ch >= "0" && ch <= "9") || (ch >= "a" && ch <= "f")
            || (ch >= "A" && ch <= "F");
    endfunction

    function automatic logic [3:0] hv(input logic [7:0] ch);
        logic [7:0] v;
        if (ch <= "9") v = ch - "0";
        else           v = (ch | 8'h20) - "a" + 8'd10;
        return v[3:0];
    endfunction

    // Whole-line reference: ok/wr/a/d for a good command, ep = index
    // of the offending byte for a bad one (-1 if none).
    function automatic void parse_line(input string s, output int ep,
                                       output bit ok, output bit wr,
                                       output logic [15:0] a,
                                       output logic [31:0] d);
        logic [7:0] c[$];
        int         p[$];
        int         j, n;
        string      kw;
        ep = -1; ok = 0; wr = 0; a = '0; d = '0;
        for (int i = 0; i < s.len(); i++)
            if (s[i] != 8'h0D) begin
                c.push_back(s[i]);
                p.push_back(i);
            end
        j = 0;
        while (c[j] == " ") j++;
        if (c[j] == 8'h0A) return;
        if (c[j] == "w") begin kw = "write"; wr = 1; end
        else if (c[j] == "r") kw = "read";
        else begin ep = p[j]; return; end
        for (int k = 0; k < kw.len(); k++) begin
            if (c[j] != kw[k]) begin ep = p[j]; return; end
            j++;
        end
        if (c[j] != " ") begin ep = p[j]; return; end
        while (c[j] == " ") j++;
        n = 0;
        while (hx(c[j])) begin
            if (n == 4) begin ep = p[j]; return; end
            a = (a << 4) | 16'(hv(c[j]));
            n++; j++;
        end
        if (n == 0) begin ep = p[j]; return; end
        if (wr) begin
            if (c[j] != " ") begin ep = p[j]; return; end
            while (c[j] == " ") j++;
            n = 0;
            while (hx(c[j])) begin
                if (n == 8) begin ep = p[j]; return; end
                d = (d << 4) | 32'(hv(c[j]));
                n++; j++;
            end
            if (n == 0) begin ep = p[j]; return; end
        end
        while (c[j] == " ") j++;
        if (c[j] != 8'h0A) begin ep = p[j]; return; end
        ok = 1;
    endfunction

    // Model: reacts to accepted bytes using the parser's annotations.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_tready <= 0; e_we <= 0; e_cs <= 0; e_irq <= 0;
            e_addr <= '0; e_wdata <= '0;
        end else begin
            e_irq <= 1'b0;
            if (e_cs) begin
                if (ack) begin
                    e_cs <= 0; e_we <= 0; e_tready <= 1;
                end
            end else begin
                e_tready <= 1'b1;
                if (tvalid && e_tready) begin
                    if (cur_err) e_irq <= 1'b1;
                    if (cur_fin) begin
                        e_cs     <= 1'b1;
                        e_we     <= cur_wr;
                        e_addr   <= cur_addr;
                        e_wdata  <= cur_wr ? cur_data : 32'h0;
                        e_tready <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_tready", 64'(tready), 64'(e_tready));
        check("cyc_cs",     64'(cs),     64'(e_cs));
        check("cyc_we",     64'(we),     64'(e_we));
        check("cyc_irq",    64'(irq),    64'(e_irq));
        check("cyc_addr",   64'(addr),   64'(e_addr));
        check("cyc_wdata",  64'(wdata),  64'(e_wdata));
        if (irq) irq_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input bit er,
                             input bit fin);
        int g;
        @(negedge clk);
        tvalid = 1; tdata = b; cur_err = er; cur_fin = fin;
        g = 0;
        while (!e_tready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            check("tready_timeout", 64'(e_tready), 64'd1);
            tvalid = 0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        tvalid = 0; cur_err = 0; cur_fin = 0;
    endtask

    task automatic send_line(input string s);
        int          ep;
        bit          ok, wr;
        logic [15:0] a;
        logic [31:0] d;
        parse_line(s, ep, ok, wr, a, d);
        cur_wr = wr; cur_addr = a; cur_data = d;
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], i == ep, ok && i == s.len() - 1);
    endtask

    task automatic pulse_ack;
        @(negedge clk) ack = 1;
        @(negedge clk) ack = 0;
    endtask

    task automatic pin(input string s, input int x_ep, input bit x_ok,
                       input logic [15:0] x_a, input logic [31:0] x_d);
        int          ep;
        bit          ok, wr;
        logic [15:0] a;
        logic [31:0] d;
        parse_line(s, ep, ok, wr, a, d);
        check("pin_ep", 64'(ep), 64'(x_ep));
        check("pin_ok", 64'(ok), 64'(x_ok));
        check("pin_a",  64'(a),  64'(x_a));
        check("pin_d",  64'(d),  64'(x_d));
    endtask

    string bad_lines[] = '{
        "write 12345 1\n", "write 1 1g\n", "read 5 6\n", "write 1\n",
        "write1 2\n", "read \n", "read 00000\n", "write 0 123456789\n",
        "Write 1 2\n", "read 1 \r x\n"
    };
    string good_lines[] = '{
        "write FFFF ffffffff\n", "read 0000\n", "read 12 \n",
        "\r read\r 3c\r\n", "write 0 00000000\n"
    };

    initial begin
        int base;
        pin("write 1f deadbeef\n", -1, 1, 16'h001F, 32'hDEADBEEF);
        pin("wrxte 1 2\n", 2, 0, 16'h0, 32'h0);
        pin("write 12345 1\n", 10, 0, 16'h1234, 32'h0);
        pin("  write  10   ff \r\n", -1, 1, 16'h0010, 32'hFF);

        repeat (3) @(negedge clk);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_cs", 64'(cs), 64'd0);
        reset = 0;

        send_line("write 1f deadbeef\n");
        repeat (12) @(negedge clk);
        check("w_cs", 64'(cs), 64'd1);
        check("w_we", 64'(we), 64'd1);
        check("w_addr", 64'(addr), 64'h001F);
        check("w_wdata", 64'(wdata), 64'hDEADBEEF);
        check("w_tready_held", 64'(tready), 64'd0);
        check("w_no_irq", 64'(irq_cnt), 64'd0);
        pulse_ack;
        check("w_rel_cs", 64'(cs), 64'd0);
        check("w_rel_tready", 64'(tready), 64'd1);

        send_line("read ABCD\n");
        check("r_cs", 64'(cs), 64'd1);
        check("r_we", 64'(we), 64'd0);
        check("r_addr", 64'(addr), 64'hABCD);
        check("r_wdata", 64'(wdata), 64'd0);
        repeat (3) @(negedge clk);
        pulse_ack;
        check("r_rel_cs", 64'(cs), 64'd0);

        pulse_ack;

        base = irq_cnt;
        send_line("wrxte 1 2\n");
        check("kw_irq", 64'(irq_cnt - base), 64'd1);
        check("kw_no_cs", 64'(cs), 64'd0);
        send_line("write 2 3\n");
        check("w23_addr", 64'(addr), 64'h2);
        check("w23_wdata", 64'(wdata), 64'h3);
        pulse_ack;

        foreach (bad_lines[i]) begin
            base = irq_cnt;
            send_line(bad_lines[i]);
            repeat (2) @(negedge clk);
            check("bad_irq", 64'(irq_cnt - base), 64'd1);
            check("bad_no_cs", 64'(cs), 64'd0);
        end

        base = irq_cnt;
        send_line("\n");
        send_line("  \r\n");
        check("blank_no_irq", 64'(irq_cnt - base), 64'd0);

        send_line("  write  10   ff \r\n");
        check("sp_addr", 64'(addr), 64'h0010);
        check("sp_wdata", 64'(wdata), 64'hFF);
        pulse_ack;

        foreach (good_lines[i]) begin
            send_line(good_lines[i]);
            check("good_cs", 64'(cs), 64'd1);
            pulse_ack;
        end

        // ack already high when cs rises: released one edge later
        ack = 1;
        send_line("read 1\n");
        check("early_ack_cs", 64'(cs), 64'd1);
        @(negedge clk);
        check("early_ack_rel", 64'(cs), 64'd0);
        ack = 0;

        send_byte("w", 0, 0);
        send_byte("r", 0, 0);
        send_byte("i", 0, 0);
        send_byte("t", 0, 0);
        send_byte("e", 0, 0);
        send_byte(" ", 0, 0);
        send_byte("1", 0, 0);
        #2 reset = 1;
        @(negedge clk);
        check("mid_rst_tready", 64'(tready), 64'd0);
        check("mid_rst_addr", 64'(addr), 64'd0);
        check("mid_rst_wdata", 64'(wdata), 64'd0);
        check("mid_rst_cs", 64'(cs), 64'd0);
        repeat (2) @(negedge clk);
        reset = 0;
        send_line("read 7\n");
        check("post_rst_addr", 64'(addr), 64'h7);
        check("post_rst_cs", 64'(cs), 64'd1);
        check("post_rst_we", 64'(we), 64'd0);
        check("post_rst_wdata", 64'(wdata), 64'd0);
        pulse_ack;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ascii_command_decoder.md
Name: ascii_command_decoder

Overview:
Byte-stream command parser that turns ASCII text lines into single bus transactions. It sits between a UART/console byte source (valid/ready stream) and a simple register bus (cs/we/addr/wdata with ack). It accepts two commands, "write <addr> <data>\n" and "read <addr>\n", with hexadecimal fields. Malformed lines are reported via an irq pulse.

Parameters:
ADDR_W, 16, address width in bits; must be a multiple of 4; maximum address digits = ADDR_W/4.
DATA_W, 32, data width in bits; must be a multiple of 4; maximum data digits = DATA_W/4.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
tvalid  input  1  input byte valid.
tdata  input  8  ASCII input byte.
tready  output  1  decoder can accept a byte.
addr  output  ADDR_W  bus address, zero-extended parsed value.
wdata  output  DATA_W  bus write data, zero-extended parsed value; 0 for read.
we  output  1  write enable, high with cs for write commands.
cs  output  1  bus request; held until ack.
irq  output  1  one-cycle pulse on a syntax error.
ack  input  1  bus completion, sampled only while cs=1.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). While reset is high, all outputs are 0 (tready=0, cs=0, we=0, irq=0, addr=0, wdata=0) and the state is IDLE. A command in progress is discarded by reset.
- Byte transfer occurs at a rising edge with tvalid && tready. A byte is consumed exactly once per handshake.
- tready=1 in all parse states and 0 in ISSUE.
- All outputs are registered.
- States:
  - IDLE/KEYWORD: matches lowercase "write" or "read" character by character. Leading spaces and '\r' are ignored. '\n' with no keyword stays in IDLE without an error.
  - SP1: requires at least one space after the keyword. Extra spaces are skipped.
  - ADDR: accepts hex digits 0-9, a-f, A-F; accumulator = (acc<<4)|nibble. A space ends the field for write (go to SP2). '\n' ends the field for read (go to ISSUE).
  - SP2: skips extra spaces before the data field.
  - DATA: accepts hex digits into the data accumulator. '\n' goes to ISSUE.
  - ISSUE: cs=1, we=1 for write and 0 for read, addr/wdata stable. Stays here until ack=1 is sampled at an edge. At that edge cs and we drop, the state returns to IDLE, and tready rises.
  - FLUSH: discards bytes until '\n', then returns to IDLE.
- '\r' is ignored in every parse state. Spaces after the last field, before '\n', are allowed.
- Latency: the edge that accepts the terminating '\n' also registers cs=1 (and we). cs is visible in the following cycle.
- Error conditions:
  - Wrong keyword character.
  - Missing separator space.
  - Non-hex character in a field.
  - Empty field.
  - More than ADDR_W/4 or DATA_W/4 digits.
  - '\n' arriving before the required fields are complete, or a data field given for read.
- On an error, irq pulses for exactly one cycle, no bus request is issued, and addr/wdata keep their previous values. If the offending byte is '\n', the state goes to IDLE; otherwise it goes to FLUSH.
- ack while cs=0 is ignored. ack arriving in the same cycle cs rises counts only if sampled at a later edge with cs=1.
- Leading zeros count toward the digit limit.

Decomposition:
- Package ascii_cmd_pkg: state enum (IDLE, KEYWORD, SP1, ADDR, SP2, DATA, ISSUE, FLUSH); ASCII constants (SPACE 8'h20, LF 8'h0A, CR 8'h0D); keyword byte strings; command-type enum (CMD_WRITE, CMD_READ).
- One natural sub-module: hex_char_decoder. It is combinational: 8-bit ASCII in, 4-bit nibble plus is_hex flag out.

Test Plan:
- Stream "write 1f deadbeef\n", one byte per handshake, tvalid high one cycle per byte -> after '\n', cs=1, we=1, addr=16'h001F, wdata=32'hDEADBEEF, irq never high. Outputs are held stable and tready=0 for 10+ cycles with ack=0; ack=1 for one cycle -> cs=we=0 and tready=1 the next cycle.
- "read ABCD\n" then ack -> cs=1, we=0, addr=16'hABCD, wdata=0; released on ack.
- "wrxte 1 2\n" -> single irq pulse at 'x', remaining bytes flushed, no cs. A following valid "write 2 3\n" -> addr=2, wdata=3.
- "write 12345 1\n" (5 addr digits) and "write 1 1g\n" -> irq pulse each, no cs.
- "  write  10   ff \r\n" (extra spaces, CR) -> addr=16'h0010, wdata=32'h000000FF.
- Assert reset mid-line after "write 1" -> all outputs 0. Stream "read 7\n" after reset release -> addr=7, cs=1, we=0, with no residue from the aborted line.
